// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and helpers for the FIFO read-side drain stage
package cdc_pkg;

  // Drain FSM: EMPTY holds nothing, SERIAL holds one word being sliced out.
  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    SERIAL = 1'b1
  } state_e;

  // Number of output beats carved from one FIFO word.
  function automatic int ratio_f(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Slice counter type for the default 32->8 configuration.
  localparam int DEF_IN_W  = 32;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_SEL_W = $clog2(ratio_f(DEF_IN_W, DEF_OUT_W));
  typedef logic [DEF_SEL_W-1:0] sel_t;

endpackage

// File: rtl/fifo_rd_downsizer.sv
// rtl/fifo_rd_downsizer.sv - pops wide FIFO words and streams them out as narrow beats
module fifo_rd_downsizer
  import cdc_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [IN_W-1:0]  fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic             flush,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam int RATIO = ratio_f(IN_W, OUT_W);
  localparam int SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(RATIO - 1);

  generate
    if ((RATIO < 2) || ((IN_W % OUT_W) != 0)) begin : g_bad_ratio
      $error("fifo_rd_downsizer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] slice_idx;
  logic             accept;
  logic             last_acc;

  // Stream outputs decode purely from held state so they stay stable under backpressure.
  always_comb begin
    m_valid   = (state_q == SERIAL);
    m_last    = (state_q == SERIAL) && (sel_q == SEL_LAST);
    busy      = m_valid;
    slice_idx = LSB_FIRST ? sel_q : (SEL_LAST - sel_q);
    m_data    = '0;
    if (state_q == SERIAL) begin
      m_data = word_q[int'(slice_idx) * OUT_W +: OUT_W];
    end
  end

  // Pop when idle or when the final beat leaves, so words chain with no bubble; flush blocks it.
  always_comb begin
    accept   = m_valid && m_ready;
    last_acc = accept && m_last;
    fifo_pop = !flush && !fifo_empty && ((state_q == EMPTY) || last_acc);
  end

  // Next-state: flush wins, then reload on pop, then advance or retire on accept.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = EMPTY;
      sel_d   = '0;
    end else if (fifo_pop) begin
      state_d = SERIAL;
      word_d  = fifo_data;
      sel_d   = '0;
    end else if (accept) begin
      if (m_last) begin
        state_d = EMPTY;
        sel_d   = '0;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  // State registers share the FIFO read-side asynchronous reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= EMPTY;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// tb/tb_fifo_rd_downsizer.sv - scoreboard bench for fifo_rd_downsizer (LSB and MSB first instances)
module tb_fifo_rd_downsizer;

  logic        clk;
  logic        n_rst;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        flush;
  logic        m_ready;

  logic        fifo_pop0, fifo_pop1;
  logic [7:0]  m_data0, m_data1;
  logic        m_valid0, m_valid1;
  logic        m_last0, m_last1;
  logic        busy0, busy1;

  int vectors;
  int miscompares;
  int pop_count;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fifo_q[$];
  logic        pop_seen;

  fifo_rd_downsizer #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .n_rst(n_rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop0), .flush(flush), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready), .m_last(m_last0), .busy(busy0)
  );

  fifo_rd_downsizer #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .n_rst(n_rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop1), .flush(flush), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready), .m_last(m_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic fifo_write(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_refresh();
  endtask

  // Expected beats for the first n slices of a word, both slice orders.
  task automatic push_word(input logic [31:0] w, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d0   = w[8*k +: 8];
      b.d1   = w[8*(3-k) +: 8];
      b.last = (k == 3);
      exp_q.push_back(b);
    end
  endtask

  // FIFO model: pop observed at the clock edge, head advanced at the following negedge.
  always @(posedge clk) begin
    pop_seen <= fifo_pop0 & n_rst;
    if (fifo_pop0 && n_rst) pop_count <= pop_count + 1;
  end

  always @(negedge clk) begin
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
  end

  // Monitor: one sample per cycle just before the active edge.
  logic       prev_stall, prev_flush, prev_rst, prev_last;
  logic [7:0] prev_data;
  always begin
    beat_t e;
    @(negedge clk);
    #4;
    if (n_rst) begin
      chk("pop_match", {31'h0, fifo_pop1}, {31'h0, fifo_pop0});
      if (fifo_empty) chk("pop_while_empty", {31'h0, fifo_pop0}, 32'h0);
      if (prev_stall && !prev_flush && prev_rst) begin
        chk("stall_valid", {31'h0, m_valid0}, 32'h1);
        chk("stall_data", {24'h0, m_data0}, {24'h0, prev_data});
        chk("stall_last", {31'h0, m_last0}, {31'h0, prev_last});
      end
      if (m_valid0 && m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %h expected no beat at %0t", m_data0, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_lsb", {24'h0, m_data0}, {24'h0, e.d0});
          chk("beat_msb", {24'h0, m_data1}, {24'h0, e.d1});
          chk("last_lsb", {31'h0, m_last0}, {31'h0, e.last});
          chk("last_msb", {31'h0, m_last1}, {31'h0, e.last});
        end
      end
    end
    prev_stall = m_valid0 && !m_ready;
    prev_data  = m_data0;
    prev_last  = m_last0;
    prev_flush = flush;
    prev_rst   = n_rst;
  end

  task automatic cyc();
    @(negedge clk);
    #4;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (exp_q.size() == 0 && !m_valid0) break;
    end
    chk({name, "_drained"}, exp_q.size(), 32'h0);
    chk({name, "_idle"}, {31'h0, m_valid0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pc;
    vectors = 0; miscompares = 0; pop_count = 0;
    n_rst = 1'b0; flush = 1'b0; m_ready = 1'b0;
    prev_stall = 1'b0; prev_flush = 1'b0; prev_rst = 1'b0;
    prev_data = 8'h0; prev_last = 1'b0;
    fifo_refresh();
    #3;
    chk("rst_valid", {31'h0, m_valid0}, 32'h0);
    chk("rst_last", {31'h0, m_last0}, 32'h0);
    chk("rst_data", {24'h0, m_data0}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_pop", {31'h0, fifo_pop0}, 32'h0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    cyc();

    // 1: single word, no backpressure
    @(negedge clk);
    m_ready = 1'b1;
    pc = pop_count;
    push_word(32'hA1B2C3D4, 4);
    fifo_write(32'hA1B2C3D4);
    #4;
    chk("t1_pop", {31'h0, fifo_pop0}, 32'h1);
    chk("t1_no_beat_yet", {31'h0, m_valid0}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_valid", {31'h0, m_valid0}, 32'h1);
      chk("t1_last", {31'h0, m_last0}, {31'h0, (i == 3)});
    end
    cyc();
    chk("t1_end_valid", {31'h0, m_valid0}, 32'h0);
    chk("t1_fifo_empty", {31'h0, fifo_empty}, 32'h1);
    chk("t1_pops", pop_count - pc, 32'h1);

    // 2: back-to-back words, no gap, pop with last accept
    @(negedge clk);
    push_word(32'h03020100, 4);
    push_word(32'h07060504, 4);
    fifo_write(32'h03020100);
    fifo_write(32'h07060504);
    #4;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t2_no_gap", {31'h0, m_valid0}, 32'h1);
      chk("t2_data", {24'h0, m_data0}, i);
      if (i == 3) chk("t2_pop_on_last", {31'h0, fifo_pop0}, 32'h1);
      if (i == 3 || i == 7) chk("t2_last", {31'h0, m_last0}, 32'h1);
    end
    drain("t2");

    // 3: backpressure on C3
    @(negedge clk);
    push_word(32'hA1B2C3D4, 4);
    fifo_write(32'hA1B2C3D4);
    #4;
    cyc();
    chk("t3_first", {24'h0, m_data0}, 32'hD4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_ready = 1'b0;
      #4;
      chk("t3_hold_valid", {31'h0, m_valid0}, 32'h1);
      chk("t3_hold_data", {24'h0, m_data0}, 32'hC3);
      chk("t3_hold_pop", {31'h0, fifo_pop0}, 32'h0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    drain("t3");

    // 5: flush after C3 accepted, FIFO still holds the next word
    @(negedge clk);
    push_word(32'hA1B2C3D4, 2);
    push_word(32'h11223344, 4);
    fifo_write(32'hA1B2C3D4);
    fifo_write(32'h11223344);
    #4;
    cyc();
    chk("t5_d4", {24'h0, m_data0}, 32'hD4);
    cyc();
    chk("t5_c3", {24'h0, m_data0}, 32'hC3);
    @(negedge clk);
    m_ready = 1'b0;
    flush = 1'b1;
    #4;
    chk("t5_flush_pop", {31'h0, fifo_pop0}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    m_ready = 1'b1;
    #4;
    chk("t5_after_flush_valid", {31'h0, m_valid0}, 32'h0);
    chk("t5_after_flush_pop", {31'h0, fifo_pop0}, 32'h1);
    drain("t5");

    // 6: reset while B2 is held
    @(negedge clk);
    push_word(32'hA1B2C3D4, 2);
    fifo_write(32'hA1B2C3D4);
    #4;
    cyc();
    cyc();
    @(negedge clk);
    m_ready = 1'b0;
    #4;
    chk("t6_b2", {24'h0, m_data0}, 32'hB2);
    #2;
    n_rst = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    #1;
    chk("t6_rst_valid", {31'h0, m_valid0}, 32'h0);
    chk("t6_rst_last", {31'h0, m_last0}, 32'h0);
    chk("t6_rst_data", {24'h0, m_data0}, 32'h0);
    chk("t6_rst_busy", {31'h0, busy1}, 32'h0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_ready = i[0];
      #4;
      chk("t6_idle_pop", {31'h0, fifo_pop0}, 32'h0);
      chk("t6_idle_valid", {31'h0, m_valid0}, 32'h0);
    end

    // Recovery after reset
    @(negedge clk);
    m_ready = 1'b1;
    push_word(32'h55667788, 4);
    fifo_write(32'h55667788);
    drain("t6_recover");

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
